// File: rtl/note_player_env.sv
// Single-voice note player: beat-timed notes with a linear attack/release gain
// envelope, driving a phase-accumulator sine reader and the codec sample handshake.

module frequency_rom (
    input  logic        clk,
    input  logic [5:0]  addr,
    output logic [19:0] dout
);
    // Linear tuning: each note code adds 1/256 of a turn of the 22-bit phase per sample.
    // NOTE: ROM output registers carry no reset; the player only reads dout after a load has addressed it.
    always_ff @(posedge clk) begin
        dout <= {addr, 14'd0};
    end
endmodule

module sine_reader (
    input  logic               clk,
    input  logic               reset,
    input  logic [19:0]        step_size,
    input  logic               generate_next,
    output logic               sample_ready,
    output logic signed [15:0] sample
);
    logic [21:0]        phase;
    logic               pending;
    logic [5:0]         idx;
    logic [4:0]         quarter_idx;
    logic signed [15:0] magnitude;

    function automatic logic [14:0] quarter_sine(input logic [4:0] k);
        case (k)
            5'd0:  return 15'd0;     5'd1:  return 15'd3212;  5'd2:  return 15'd6393;
            5'd3:  return 15'd9512;  5'd4:  return 15'd12539; 5'd5:  return 15'd15446;
            5'd6:  return 15'd18204; 5'd7:  return 15'd20787; 5'd8:  return 15'd23170;
            5'd9:  return 15'd25329; 5'd10: return 15'd27245; 5'd11: return 15'd28898;
            5'd12: return 15'd30273; 5'd13: return 15'd31356; 5'd14: return 15'd32137;
            5'd15: return 15'd32609; default: return 15'd32767;
        endcase
    endfunction

    // Quarter-wave table: bit 4 mirrors the index, bit 5 negates the result.
    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        idx         = phase[21:16];
        quarter_idx = idx[4] ? 5'd16 - {1'b0, idx[3:0]} : {1'b0, idx[3:0]};
        magnitude   = {1'b0, quarter_sine(quarter_idx)};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase        <= '0;
            pending      <= 1'b0;
            sample_ready <= 1'b0;
            sample       <= '0;
        end else begin
            pending      <= generate_next;
            sample_ready <= pending;
            if (generate_next)
                phase <= phase + {2'b00, step_size};
            if (pending)
                sample <= idx[5] ? -magnitude : magnitude;
        end
    end
endmodule

module note_player_env #(
    parameter int DUR_W     = 6,
    parameter int ENV_W     = 8,
    parameter int ENV_INC   = 4,
    parameter int REST_NOTE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_enable,
    input  logic [5:0]         note_to_load,
    input  logic [DUR_W-1:0]   duration_to_load,
    input  logic               load_new_note,
    input  logic               beat,
    input  logic               generate_next_sample,
    output logic               done_with_note,
    output logic signed [15:0] sample_out,
    output logic               new_sample_ready
);
    typedef enum logic [1:0] {IDLE, FETCH, PLAY, DONE} state_t;

    localparam logic [ENV_W:0] GAIN_MAX  = (ENV_W+1)'(1) << ENV_W;
    localparam logic [ENV_W:0] GAIN_STEP = (ENV_W+1)'(ENV_INC);
    localparam logic [5:0]     REST      = 6'(REST_NOTE);

    state_t                     state;
    logic [5:0]                 note;
    logic [DUR_W-1:0]           duration;
    logic [DUR_W-1:0]           beat_count;
    logic [DUR_W-1:0]           beat_next;
    logic [19:0]                step;
    logic [ENV_W:0]             gain;
    logic [ENV_W:0]             gain_next;
    logic [5:0]                 rom_addr;
    logic [19:0]                rom_dout;
    logic                       sr_request;
    logic                       sr_ready;
    logic signed [15:0]         raw;
    logic signed [ENV_W+17:0]   product;

    // The ROM is addressed with the incoming note on the load cycle so dout is valid during FETCH.
    always_comb begin
        rom_addr   = load_new_note ? note_to_load : note;
        sr_request = generate_next_sample && play_enable && (state == PLAY || state == DONE);
        beat_next  = beat_count + 1'b1;
        if (state == PLAY && note != REST)
            gain_next = (gain >= GAIN_MAX - GAIN_STEP) ? GAIN_MAX : gain + GAIN_STEP;
        else
            gain_next = (gain <= GAIN_STEP) ? '0 : gain - GAIN_STEP;
        product = raw * $signed({1'b0, gain_next});
    end

    frequency_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .dout (rom_dout)
    );

    sine_reader u_sine (
        .clk           (clk),
        .reset         (reset),
        .step_size     (step),
        .generate_next (sr_request),
        .sample_ready  (sr_ready),
        .sample        (raw)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            note             <= '0;
            duration         <= '0;
            beat_count       <= '0;
            step             <= '0;
            gain             <= '0;
            done_with_note   <= 1'b0;
            sample_out       <= '0;
            new_sample_ready <= 1'b0;
        end else begin
            new_sample_ready <= 1'b0;
            // A sample still in flight when playback pauses is dropped, keeping the gain frozen.
            if (sr_ready && play_enable) begin
                gain             <= gain_next;
                sample_out       <= product[ENV_W+15:ENV_W];
                new_sample_ready <= 1'b1;
            end

            if (load_new_note) begin
                note           <= note_to_load;
                duration       <= duration_to_load;
                beat_count     <= '0;
                done_with_note <= 1'b0;
                state          <= FETCH;
            end else begin
                case (state)
                    IDLE: ;
                    FETCH: begin
                        step <= (note == REST) ? 20'd0 : rom_dout;
                        if (duration == '0) begin
                            state          <= DONE;
                            done_with_note <= 1'b1;
                        end else begin
                            state <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (beat && play_enable) begin
                            beat_count <= beat_next;
                            if (beat_next == duration) begin
                                state          <= DONE;
                                done_with_note <= 1'b1;
                            end
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
